// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the memory responder: FSM states, latched
// operation codes and the access classification used at acceptance.
package mem_resp_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int DATA_W_DEF      = 32;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_BAD
  } op_t;

  // Rejected: both strobes, misaligned byte address, or beyond the word array.
  function automatic op_t classify(input logic rd, input logic wr,
                                   input logic [31:0] addr, input int addr_w);
    logic [31:0] hi_bits;
    hi_bits = addr >> (addr_w + 2);
    if ((rd && wr) || (addr[1:0] != 2'b00) || (hi_bits != 32'd0)) begin
      return OP_BAD;
    end
    return rd ? OP_RD : OP_WR;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with write enable and an enabled,
// registered read port that holds its value between reads.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for the multicycle CPU: accepts one word access,
// waits WAIT_CYCLES, then pulses mem_ready (with err for rejected accesses).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              err,
  output logic              busy
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              err_q, err_d;
  logic              rd_valid_q, rd_valid_d;

  logic              entering;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign entering = (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_RD;
      idx_q       <= '0;
      wdata_q     <= '0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      mem_ready_q <= mem_ready_d;
      err_q       <= err_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          op_d    = classify(MemRead, MemWrite, addr, ADDR_W);
          idx_d   = addr[ADDR_W+1:2];
          wdata_d = wdata;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM port is shared: the access owns it on the RESPOND-entry edge,
  // otherwise an idle preload with no competing request may use it.
  always_comb begin
    mem_ready_d = entering;
    err_d       = entering && (op_q == OP_BAD);
    rd_valid_d  = rd_valid_q;
    ram_re      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = prog_addr;
    ram_wdata   = prog_data;
    if (entering) begin
      ram_addr  = idx_q;
      ram_wdata = wdata_q;
      ram_re    = (op_q == OP_RD);
      ram_we    = (op_q == OP_WR);
      if (op_q == OP_RD) begin
        rd_valid_d = 1'b1;
      end else if (op_q == OP_BAD) begin
        rd_valid_d = 1'b0;
      end
    end else if ((state_q == IDLE) && !MemRead && !MemWrite && prog_we) begin
      ram_we = 1'b1;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // RAM output register is not reset, so a cleared flag masks it to zero.
  assign rdata     = rd_valid_q ? ram_rdata : '0;
  assign mem_ready = mem_ready_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory responder for the multicycle CPU. It is the far end of the controller's MemRead/MemWrite interface: it accepts one word access per request, inserts a fixed number of wait states, and returns a one-cycle mem_ready pulse so the controller can stall in its memory states. It serves both instruction fetch (IRWrite path) and data load/store from a single unified word array. It flags misaligned and out-of-range accesses instead of performing them.

## Interface
- ADDR_W, 8: word-address width; array holds 2^ADDR_W words.
- DATA_W, 32: data word width.
- WAIT_CYCLES, 2: wait states between acceptance and response (0 allowed).
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request (level) from the controller.
- MemWrite  in  1  write request (level) from the controller.
- addr  in  32  byte address; bits [1:0] must be 00.
- wdata  in  DATA_W  store data, sampled at acceptance.
- prog_we  in  1  preload write strobe; honoured only in IDLE with no request.
- prog_addr  in  ADDR_W  preload word address.
- prog_data  in  DATA_W  preload word.
- rdata  out  DATA_W  read data; valid in the mem_ready cycle and held afterwards.
- mem_ready  out  1  one-cycle completion pulse.
- err  out  1  high with mem_ready when the access was rejected.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, WAIT, RESPOND.
- IDLE: on an edge with MemRead or MemWrite high, latch op, addr and wdata, load cnt = WAIT_CYCLES, go to WAIT. Later input changes are ignored until the next acceptance.
- WAIT: when cnt == 0, go to RESPOND; otherwise decrement cnt.
- On the edge entering RESPOND:
  - Valid read: rdata <= array[addr[ADDR_W+1:2]].
  - Valid write: array[addr[ADDR_W+1:2]] <= wdata; rdata is unchanged.
  - mem_ready <= 1.
  - err <= 1 if the access is rejected.
- RESPOND lasts one cycle, then returns to IDLE unconditionally. A request still high in that IDLE cycle is accepted as a new access.
- Rejected accesses (no array change, rdata <= 0):
  - addr[1:0] != 00.
  - addr[31:ADDR_W+2] != 0.
  - MemRead and MemWrite both high at acceptance.
- Preload: when prog_we is high in IDLE with no request pending, array[prog_addr] <= prog_data. If a request is present in the same cycle, the request wins and the preload is dropped.
- The array is not cleared by reset; contents survive reset.

## Timing
- Reset values: rdata = 0, mem_ready = 0, err = 0, busy = 0, state = IDLE, cnt = 0.
- Accepted at edge E0: mem_ready is high from edge E0+WAIT_CYCLES+1 to edge E0+WAIT_CYCLES+2.
- Earliest next acceptance is edge E0+WAIT_CYCLES+3, so one access completes per WAIT_CYCLES+3 cycles.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset asserted mid-access: return to IDLE immediately; a pending write is discarded; mem_ready and err drop.
- Width rule: the word index is addr[ADDR_W+1:2]; cnt width is clog2(WAIT_CYCLES+1), minimum 1 bit.

## Structure
- Package mem_resp_pkg holds:
  - the state enum (IDLE, WAIT, RESPOND);
  - the op encoding (OP_RD, OP_WR, OP_BAD);
  - the defaults for ADDR_W, DATA_W and WAIT_CYCLES.
- One sub-module, mem_array: a single-port synchronous RAM with write enable. Its write port is shared between the preload path and the RESPOND write, muxed in the responder.
- The FSM, counter, request latch and error check live in mem_responder.

## Test plan
- Preload word 5 = 0xDEADBEEF via prog_we; pulse MemRead with addr 0x14 before edge E0 → mem_ready and rdata = 0xDEADBEEF after edge E0+3; err = 0; busy high for edges E0 through E0+4.
- MemWrite with addr 0x20 and wdata 0x12345678, then MemRead of 0x20 → second mem_ready returns 0x12345678.
- Read of addr 0x22 (misaligned) and of addr 0x400 (out of range for ADDR_W = 8) → mem_ready with err = 1 and rdata = 0; the array is unchanged.
- MemRead held high continuously → mem_ready pulses every 5 cycles. With WAIT_CYCLES = 0, it pulses every 3 cycles.
- Assert reset during WAIT of a write to 0x30 → outputs return to 0; a later read of 0x30 returns the preloaded value.
- MemRead and MemWrite high together → err = 1 and no array write. prog_we together with a MemRead in IDLE → the preload is ignored.
